// File: rtl/param_sequence_detector.sv
// Serial pattern detector with a loadable LEN-bit pattern, selectable
// overlapping/non-overlapping detection and a saturating match counter.
module param_sequence_detector #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PAT_RST = LEN'(4'b1101),
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             inp,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_value,
    input  logic             overlap,
    input  logic             count_clr,
    output logic             outp,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned       FILL_W    = $clog2(LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LEN - 1);

    logic [LEN-1:0]    pattern_q, pattern_d;
    logic [LEN-1:0]    history_q, history_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              outp_q, outp_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [LEN-1:0]    window_c;
    logic              accept_c;
    logic              match_c;

    // Candidate window including the incoming bit; a load cycle never accepts it
    always_comb begin
        window_c = {history_q[LEN-2:0], inp};
        accept_c = in_valid & ~pat_load;
        match_c  = accept_c && (window_c == pattern_q) && (fill_q >= FILL_LAST);
    end

    // Next-state for pattern, history, fill, match pulse and counter
    always_comb begin
        pattern_d = pattern_q;
        history_d = history_q;
        fill_d    = fill_q;
        outp_d    = match_c;
        count_d   = count_q;

        if (pat_load) begin
            pattern_d = pat_value;
            fill_d    = '0;
        end else if (accept_c) begin
            history_d = window_c;
            if (match_c) begin
                // overlap keeps the window full so the next bit can complete a match
                fill_d = overlap ? FILL_FULL : '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (count_clr) begin
            count_d = '0;
        end else if (match_c && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pattern_q <= PAT_RST;
            history_q <= '0;
            fill_q    <= '0;
            outp_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            outp_q    <= outp_d;
            count_q   <= count_d;
        end
    end

    assign outp        = outp_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed scoreboard bench: the stimulus pushes the hand-computed response
// of each cycle, and a negedge monitor pops and compares it.
module tb_param_sequence_detector;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       inp;
    logic       pat_load;
    logic [3:0] pat_value;
    logic       overlap;
    logic       count_clr;
    logic       outp;
    logic [7:0] match_count;
    logic       sat_outp;
    logic [1:0] sat_count;

    param_sequence_detector #(.LEN(4), .PAT_RST(4'b1101), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .inp(inp),
        .pat_load(pat_load), .pat_value(pat_value), .overlap(overlap),
        .count_clr(count_clr), .outp(outp), .match_count(match_count)
    );

    param_sequence_detector #(.LEN(4), .PAT_RST(4'b1101), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .in_valid(in_valid), .inp(inp),
        .pat_load(pat_load), .pat_value(pat_value), .overlap(overlap),
        .count_clr(count_clr), .outp(sat_outp), .match_count(sat_count)
    );

    typedef struct {
        int unsigned cyc;
        logic        o;
        logic [7:0]  c8;
        logic [1:0]  c2;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cycle_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  trk8 = '0;
    logic [1:0]  trk2 = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    // Monitor: compare every response whose edge has already happened
    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp = n_cmp + 3;
            if (outp !== e.o || sat_outp !== e.o) begin
                n_bad = n_bad + 1;
                $display("FAIL outp cyc=%0d got=%b/%b exp=%b", e.cyc, outp, sat_outp, e.o);
            end
            if (match_count !== e.c8) begin
                n_bad = n_bad + 1;
                $display("FAIL count8 cyc=%0d got=%0d exp=%0d", e.cyc, match_count, e.c8);
            end
            if (sat_count !== e.c2) begin
                n_bad = n_bad + 1;
                $display("FAIL count2 cyc=%0d got=%0d exp=%0d", e.cyc, sat_count, e.c2);
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic b, input logic ld,
                         input logic [3:0] pv, input logic ov, input logic clr,
                         input logic exp_o);
        exp_t e;
        @(negedge clock);
        reset     = r;
        in_valid  = v;
        inp       = b;
        pat_load  = ld;
        pat_value = pv;
        overlap   = ov;
        count_clr = clr;
        if (r || clr) begin
            trk8 = '0;
            trk2 = '0;
        end else if (exp_o) begin
            if (trk8 != 8'hFF) trk8 = trk8 + 8'd1;
            if (trk2 != 2'b11) trk2 = trk2 + 2'd1;
        end
        e.cyc = cycle_cnt + 1;
        e.o   = r ? 1'b0 : exp_o;
        e.c8  = trk8;
        e.c2  = trk2;
        sb_q.push_back(e);
    endtask

    task automatic feed(input string bs, input string es, input logic ov);
        for (int k = 0; k < bs.len(); k++)
            drive(1'b0, 1'b1, bs[k] == 8'h31, 1'b0, 4'b0000, ov, 1'b0, es[k] == 8'h31);
    endtask

    task automatic load(input logic [3:0] pv, input logic v, input logic b);
        drive(1'b0, v, b, 1'b1, pv, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; inp = 1'b1; pat_load = 1'b0;
        pat_value = 4'b0000; overlap = 1'b0; count_clr = 1'b0;

        // reset held with live input
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);

        // non-overlapping
        feed("1101101", "0001000", 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

        // overlapping
        load(4'b1101, 1'b0, 1'b0);
        feed("1101101", "0001001", 1'b1);

        // back-to-back pulses, load never matches, overlap changed mid-stream
        load(4'b1111, 1'b0, 1'b0);
        feed("111111", "000111", 1'b1);
        load(4'b1111, 1'b1, 1'b1);
        feed("1111", "0001", 1'b1);
        feed("1", "1", 1'b0);
        feed("1", "0", 1'b1);

        // gaps of in_valid=0 between bits 2 and 3
        load(4'b1101, 1'b1, 1'b1);
        feed("11", "00", 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        feed("01", "01", 1'b0);

        // reload after partial window
        feed("11", "00", 1'b0);
        load(4'b0110, 1'b1, 1'b1);
        feed("0110", "0001", 1'b0);

        // saturation, then clear coinciding with a match
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        load(4'b1101, 1'b0, 1'b0);
        feed("1101101101101", "0001001001001", 1'b1);
        feed("10", "00", 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        feed("101", "001", 1'b1);
        feed("10", "00", 1'b1);

        // asynchronous reset mid-stream, between edges
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp = n_cmp + 1;
        if (outp !== 1'b0 || match_count !== 8'd0 || sat_count !== 2'd0) begin
            n_bad = n_bad + 1;
            $display("FAIL async_reset got=%b/%0d/%0d exp=0/0/0", outp, match_count, sat_count);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        feed("1", "0", 1'b0);
        feed("101", "001", 1'b0);

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 4 && sb_q.size() > 0; k++) @(negedge clock);
        #1;
        n_cmp = n_cmp + 1;
        if (sb_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain pending=%0d exp=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
